// File: rtl/mipi_raw_depacker_param_if.sv
// mipi_raw_depacker_param_if: payload-in / pixel-out bundle for the RAW depacker
interface mipi_raw_depacker_param_if #(
  parameter int IN_BYTES = 2,
  parameter int PIX_W    = 12
);
  logic [1:0]              I_Mode;
  logic                    I_Mipi_Sync;
  logic [8*IN_BYTES-1:0]   I_Mipi_Unpacket_Data;
  logic                    I_Mipi_Unpacket_Vaild;
  logic [4*PIX_W-1:0]      O_Pix_Data;
  logic                    O_Pix_Vaild;
  logic                    O_Mode_Err;
  modport master (
    output I_Mode, I_Mipi_Sync, I_Mipi_Unpacket_Data, I_Mipi_Unpacket_Vaild,
    input  O_Pix_Data, O_Pix_Vaild, O_Mode_Err
  );
  modport slave (
    input  I_Mode, I_Mipi_Sync, I_Mipi_Unpacket_Data, I_Mipi_Unpacket_Vaild,
    output O_Pix_Data, O_Pix_Vaild, O_Mode_Err
  );
endinterface

// File: rtl/mipi_raw_depacker_param.sv
// mipi_raw_depacker_param: CSI-2 RAW8/10/12 byte stream to 4 MSB-aligned pixels per beat.
// RAW12 support is compiled in only with MIPI_DEPACK_RAW12_EN.
module mipi_raw_depacker_param #(
  parameter int IN_BYTES = 2,
  parameter int PIX_W    = 12
) (
  input logic I_CLK,
  input logic I_Rst_n,
  mipi_raw_depacker_param_if.slave bus
);
`ifdef MIPI_DEPACK_RAW12_EN
  localparam int BUF = 10;
`else
  localparam int BUF = 8;
`endif
  localparam int BW = 8 * BUF;
  typedef enum logic {IDLE, RUN} state_t;
  state_t state_q, state_d;
  logic [1:0] mode_q;
  logic err_q, legal, fire, accept, vld_q;
  logic [3:0] cnt_q, g;
  logic [4:0] sum;
  logic [BW-1:0] buf_q, merged;
  logic [PIX_W-1:0] p [4];
  logic [4*PIX_W-1:0] pix, pix_q;
  always_ff @(posedge I_CLK or negedge I_Rst_n)
    if (!I_Rst_n) state_q <= IDLE;
    else state_q <= state_d;
  always_comb begin
    state_d = bus.I_Mipi_Sync ? RUN : state_q;
`ifdef MIPI_DEPACK_RAW12_EN
    legal = bus.I_Mode != 2'b11;
`else
    legal = !bus.I_Mode[1];
`endif
    g = mode_q == 2'b00 ? 4'd4 : mode_q == 2'b01 ? 4'd5 : 4'd6;
    // buffer bytes above cnt_q are always zero, so the new beat can be OR-ed in
    merged = buf_q | (BW'(bus.I_Mipi_Unpacket_Data) << {cnt_q, 3'b000});
    sum = 5'(cnt_q) + 5'(IN_BYTES);
    accept = state_q == RUN && !err_q && bus.I_Mipi_Unpacket_Vaild && !bus.I_Mipi_Sync;
    fire = accept && sum >= 5'(g);
  end
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      p[i] = mode_q == 2'b01 ? PIX_W'({merged[8*i+:8], merged[32+2*i+:2]}) << (PIX_W-10)
                             : PIX_W'(merged[8*i+:8]) << (PIX_W-8);
`ifdef MIPI_DEPACK_RAW12_EN
      if (mode_q == 2'b10)
        p[i] = PIX_W'({merged[8*(i+i/2)+:8], merged[16+24*(i/2)+4*(i%2)+:4]}) << (PIX_W-12);
`endif
    end
    pix = {p[0], p[1], p[2], p[3]};
  end
  always_ff @(posedge I_CLK or negedge I_Rst_n)
    if (!I_Rst_n) begin
      mode_q <= 2'b00;
      err_q  <= 1'b0;
      cnt_q  <= '0;
      buf_q  <= '0;
      pix_q  <= '0;
      vld_q  <= 1'b0;
    end else begin
      vld_q <= fire;
      if (fire) pix_q <= pix;
      if (bus.I_Mipi_Sync) begin
        mode_q <= bus.I_Mode;
        err_q  <= !legal;
        cnt_q  <= '0;
        buf_q  <= '0;
      end else if (fire) begin
        buf_q <= merged >> {g, 3'b000};
        cnt_q <= 4'(sum - 5'(g));
      end else if (accept) begin
        buf_q <= merged;
        cnt_q <= sum[3:0];
      end
    end
  assign bus.O_Pix_Data  = pix_q;
  assign bus.O_Pix_Vaild = vld_q;
  assign bus.O_Mode_Err  = err_q;
endmodule

// File: tb/tb_mipi_raw_depacker_param.sv
// tb_mipi_raw_depacker_param: directed checks of the depacker at IN_BYTES=2/PIX_W=12 and IN_BYTES=4/PIX_W=16
module tb_mipi_raw_depacker_param;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int failures = 0;
  int n2 = 0;
  int n4 = 0;
  int n0;
  logic [7:0] pat [5];
  logic [31:0] wd;
  localparam logic [63:0] EXP4 = 64'h4000_8040_C080_FFC0;
  always #5 clk = ~clk;
  mipi_raw_depacker_param_if #(.IN_BYTES(2), .PIX_W(12)) a ();
  mipi_raw_depacker_param_if #(.IN_BYTES(4), .PIX_W(16)) w ();
  mipi_raw_depacker_param #(.IN_BYTES(2), .PIX_W(12)) u_a (.I_CLK(clk), .I_Rst_n(rst_n), .bus(a));
  mipi_raw_depacker_param #(.IN_BYTES(4), .PIX_W(16)) u_w (.I_CLK(clk), .I_Rst_n(rst_n), .bus(w));
  always @(posedge clk) begin
    if (a.O_Pix_Vaild) n2++;
    if (w.O_Pix_Vaild) begin
      n4++;
      checks++;
      assert (w.O_Pix_Data === EXP4) else begin
        failures++;
        $error("FAIL w_data observed=%0h expected=%0h", w.O_Pix_Data, EXP4);
      end
    end
  end
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic step(input logic s, input logic [1:0] m, input logic v, input logic [15:0] d);
    @(negedge clk);
    a.I_Mipi_Sync = s;
    a.I_Mode = m;
    a.I_Mipi_Unpacket_Vaild = v;
    a.I_Mipi_Unpacket_Data = d;
  endtask
  task automatic stepw(input logic s, input logic [1:0] m, input logic v, input logic [31:0] d);
    @(negedge clk);
    w.I_Mipi_Sync = s;
    w.I_Mode = m;
    w.I_Mipi_Unpacket_Vaild = v;
    w.I_Mipi_Unpacket_Data = d;
  endtask
  task automatic beatw(input int k, output logic [31:0] d);
    for (int b = 0; b < 4; b++) d[8*b+:8] = pat[(4*k+b)%5];
  endtask
  initial begin
    pat[0] = 8'h40; pat[1] = 8'h80; pat[2] = 8'hC0; pat[3] = 8'hFF; pat[4] = 8'hE4;
    a.I_Mipi_Sync = 0; a.I_Mode = 0; a.I_Mipi_Unpacket_Vaild = 0; a.I_Mipi_Unpacket_Data = 0;
    w.I_Mipi_Sync = 0; w.I_Mode = 0; w.I_Mipi_Unpacket_Vaild = 0; w.I_Mipi_Unpacket_Data = 0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    step(0, 2'b00, 0, 16'h0);
    chk("reset_data", 64'(a.O_Pix_Data), 64'h0);
    chk("reset_vld", 64'(a.O_Pix_Vaild), 64'h0);
    chk("reset_err", 64'(a.O_Mode_Err), 64'h0);
    step(0, 2'b00, 1, 16'h2211);
    step(0, 2'b00, 1, 16'h4433);
    step(0, 2'b00, 0, 16'h0);
    step(0, 2'b00, 0, 16'h0);
    chk("idle_ignore", 64'(n2), 64'd0);
    step(1, 2'b00, 0, 16'h0);
    step(0, 2'b00, 1, 16'h2211);
    step(0, 2'b00, 1, 16'h4433);
    step(0, 2'b00, 0, 16'h0);
    chk("raw8_vld", 64'(a.O_Pix_Vaild), 64'h1);
    chk("raw8_data", 64'(a.O_Pix_Data), 64'h110_220_330_440);
    step(0, 2'b00, 0, 16'h0);
    chk("raw8_strobe_len", 64'(a.O_Pix_Vaild), 64'h0);
    chk("raw8_hold", 64'(a.O_Pix_Data), 64'h110_220_330_440);
    step(1, 2'b01, 0, 16'h0);
    step(0, 2'b00, 1, 16'h8040);
    step(0, 2'b00, 1, 16'hFFC0);
    step(0, 2'b00, 1, 16'h00E4);
    chk("raw10_early", 64'(a.O_Pix_Vaild), 64'h0);
    step(0, 2'b00, 0, 16'h0);
    chk("raw10_vld", 64'(a.O_Pix_Vaild), 64'h1);
    chk("raw10_data", 64'(a.O_Pix_Data), 64'h400_804_C08_FFC);
    step(1, 2'b10, 0, 16'h0);
    step(0, 2'b00, 1, 16'hCDAB);
    step(0, 2'b00, 1, 16'h1221);
    step(0, 2'b00, 1, 16'h6534);
    step(0, 2'b00, 0, 16'h0);
`ifdef MIPI_DEPACK_RAW12_EN
    chk("raw12_vld", 64'(a.O_Pix_Vaild), 64'h1);
    chk("raw12_data", 64'(a.O_Pix_Data), 64'hAB1_CD2_125_346);
    chk("raw12_err", 64'(a.O_Mode_Err), 64'h0);
`else
    chk("raw12_off_vld", 64'(a.O_Pix_Vaild), 64'h0);
    chk("raw12_off_err", 64'(a.O_Mode_Err), 64'h1);
`endif
    step(1, 2'b01, 0, 16'h0);
    step(0, 2'b00, 1, 16'hBBAA);
    step(0, 2'b00, 0, 16'h0);
    step(0, 2'b00, 0, 16'h0);
    n0 = n2;
    step(1, 2'b01, 1, 16'hDDCC);
    step(0, 2'b00, 1, 16'h8040);
    step(0, 2'b00, 1, 16'hFFC0);
    step(0, 2'b00, 1, 16'h00E4);
    step(0, 2'b00, 0, 16'h0);
    chk("sync_mid_data", 64'(a.O_Pix_Data), 64'h400_804_C08_FFC);
    step(0, 2'b00, 0, 16'h0);
    step(0, 2'b00, 0, 16'h0);
    chk("sync_mid_count", 64'(n2 - n0), 64'd1);
    step(1, 2'b11, 0, 16'h0);
    step(0, 2'b00, 0, 16'h0);
    chk("err_set", 64'(a.O_Mode_Err), 64'h1);
    n0 = n2;
    step(0, 2'b00, 1, 16'h2211);
    step(0, 2'b00, 1, 16'h4433);
    step(0, 2'b00, 1, 16'h2211);
    step(0, 2'b00, 1, 16'h4433);
    step(0, 2'b00, 0, 16'h0);
    step(0, 2'b00, 0, 16'h0);
    chk("err_nostrobe", 64'(n2 - n0), 64'd0);
    chk("err_sticky", 64'(a.O_Mode_Err), 64'h1);
    step(1, 2'b00, 0, 16'h0);
    step(0, 2'b00, 0, 16'h0);
    chk("err_clear", 64'(a.O_Mode_Err), 64'h0);
    step(0, 2'b00, 1, 16'h2211);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_data", 64'(a.O_Pix_Data), 64'h0);
    chk("async_rst_vld", 64'(a.O_Pix_Vaild), 64'h0);
    @(negedge clk) rst_n = 1'b1;
    n0 = n2;
    step(0, 2'b00, 1, 16'h4433);
    step(0, 2'b00, 1, 16'h4433);
    step(0, 2'b00, 0, 16'h0);
    step(0, 2'b00, 0, 16'h0);
    chk("post_rst_idle", 64'(n2 - n0), 64'd0);
    step(1, 2'b00, 0, 16'h0);
    step(0, 2'b00, 1, 16'h2211);
    step(0, 2'b00, 1, 16'h4433);
    step(0, 2'b00, 0, 16'h0);
    chk("post_rst_data", 64'(a.O_Pix_Data), 64'h110_220_330_440);
    n0 = n4;
    stepw(1, 2'b01, 0, 32'h0);
    for (int k = 0; k < 10; k++) begin
      beatw(k, wd);
      stepw(0, 2'b00, 1, wd);
    end
    repeat (3) stepw(0, 2'b00, 0, 32'h0);
    chk("w_count", 64'(n4 - n0), 64'd8);
    n0 = n4;
    stepw(1, 2'b01, 0, 32'h0);
    for (int k = 0; k < 10; k++) begin
      beatw(k, wd);
      stepw(0, 2'b00, 1, wd);
      if (k % 3 == 0) repeat (2) stepw(0, 2'b00, 0, 32'h0);
    end
    repeat (3) stepw(0, 2'b00, 0, 32'h0);
    chk("w_gap_count", 64'(n4 - n0), 64'd8);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
